// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write arbiter: FSM state, x0 address and
// the registered write bundle.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_FORCE
    } arb_state_e;

    localparam int unsigned X0_ADDR   = 0;

    // Widths of the registered write bundle; the arbiter is built to match these.
    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus between the writers (pipeline writeback, multi-cycle unit) and the
// register-file write arbiter. RF_ARB_PERF_EN adds the two performance counters.
interface rf_write_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RD    = 5
);
    logic             wb_valid_i;
    logic [RD-1:0]    wb_addr_i;
    logic [WIDTH-1:0] wb_data_i;
    logic             mc_valid_i;
    logic [RD-1:0]    mc_addr_i;
    logic [WIDTH-1:0] mc_data_i;
    logic             mc_ready_o;
    logic             rf_we_o;
    logic [RD-1:0]    rf_waddr_o;
    logic [WIDTH-1:0] rf_wdata_o;
    logic             stall_pipe_o;
`ifdef RF_ARB_PERF_EN
    logic [15:0]      conflict_cnt_o;
    logic [15:0]      force_cnt_o;

    modport master (
        output wb_valid_i, wb_addr_i, wb_data_i, mc_valid_i, mc_addr_i, mc_data_i,
        input  mc_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_pipe_o,
        input  conflict_cnt_o, force_cnt_o
    );

    modport slave (
        input  wb_valid_i, wb_addr_i, wb_data_i, mc_valid_i, mc_addr_i, mc_data_i,
        output mc_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_pipe_o,
        output conflict_cnt_o, force_cnt_o
    );
`else
    modport master (
        output wb_valid_i, wb_addr_i, wb_data_i, mc_valid_i, mc_addr_i, mc_data_i,
        input  mc_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_pipe_o
    );

    modport slave (
        input  wb_valid_i, wb_addr_i, wb_data_i, mc_valid_i, mc_addr_i, mc_data_i,
        output mc_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_pipe_o
    );
`endif
endinterface

// File: rtl/rf_arb_wait_counter.sv
// Saturating count of consecutive cycles the multi-cycle unit has been blocked.
// thresh flags that the next increment reaches MAX_WAIT; it is derived from the
// registered count only, so the FSM can use it without a combinational loop.
module rf_arb_wait_counter #(
    parameter int unsigned MAX_WAIT = 8,
    localparam int unsigned CNT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr,
    input  logic inc,
    output logic thresh
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear wins, increment saturates at MAX_WAIT.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_W'(MAX_WAIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign thresh = (count_q >= CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: WB has fixed priority, MC uses valid/ready, the
// winning write is registered one cycle before reaching the RF, writes to x0
// are filtered, and a starvation FSM stalls the pipeline so MC makes progress.
// Optional macro RF_ARB_PERF_EN adds saturating conflict/force counters.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned RD       = 5,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    rf_write_arbiter_if.slave  bus
);

    // The registered bundle type is fixed by the package widths.
    if ((WIDTH != RF_DATA_W) || (RD != RF_ADDR_W)) begin : g_width_check
        $error("rf_write_arbiter: WIDTH/RD must match rf_arb_pkg widths");
    end

    logic       wb_eff, mc_ready, mc_xfer, mc_blocked;
    logic       cnt_clr, cnt_inc, cnt_thresh;
    logic       stall_q;
    arb_state_e state_q, state_d;
    rf_wr_t     rf_q, rf_d;

    // Request qualification; mc_ready deliberately ignores mc_valid_i.
    always_comb begin
        wb_eff     = bus.wb_valid_i && (bus.wb_addr_i != RD'(X0_ADDR));
        mc_ready   = rst_ni && !wb_eff;
        mc_xfer    = bus.mc_valid_i && mc_ready;
        mc_blocked = bus.mc_valid_i && !mc_ready;
    end

    // Grant selection; address/data hold when nobody is granted.
    always_comb begin
        rf_d    = rf_q;
        rf_d.we = 1'b0;
        if (wb_eff) begin
            rf_d.we   = 1'b1;
            rf_d.addr = bus.wb_addr_i;
            rf_d.data = bus.wb_data_i;
        end else if (mc_xfer) begin
            // x0 results complete the handshake but never write.
            rf_d.we   = (bus.mc_addr_i != RD'(X0_ADDR));
            rf_d.addr = bus.mc_addr_i;
            rf_d.data = bus.mc_data_i;
        end
    end

    // Starvation FSM next state and counter control.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (mc_blocked) begin
                    cnt_inc = 1'b1;
                    state_d = cnt_thresh ? ARB_FORCE : ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // A dropped mc_valid_i is a protocol violation; just recover.
                if (mc_xfer || !bus.mc_valid_i) begin
                    cnt_clr = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                    if (cnt_thresh) begin
                        state_d = ARB_FORCE;
                    end
                end
            end
            ARB_FORCE: begin
                // WB keeps priority for the in-flight cycle after the stall rises.
                if (mc_xfer || !bus.mc_valid_i) begin
                    cnt_clr = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = ARB_IDLE;
            end
        endcase
    end

    rf_arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .thresh (cnt_thresh)
    );

    // State, stall and RF write registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            stall_q <= 1'b0;
            rf_q    <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= (state_d == ARB_FORCE);
            rf_q    <= rf_d;
        end
    end

    assign bus.mc_ready_o   = mc_ready;
    assign bus.rf_we_o      = rf_q.we;
    assign bus.rf_waddr_o   = rf_q.addr;
    assign bus.rf_wdata_o   = rf_q.data;
    assign bus.stall_pipe_o = stall_q;

`ifdef RF_ARB_PERF_EN
    logic [15:0] conflict_q, force_q;

    // Saturating event counters: WB/MC conflicts and entries into FORCE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            conflict_q <= '0;
            force_q    <= '0;
        end else begin
            if (wb_eff && bus.mc_valid_i && (conflict_q != 16'hFFFF)) begin
                conflict_q <= conflict_q + 16'd1;
            end
            if ((state_q != ARB_FORCE) && (state_d == ARB_FORCE) && (force_q != 16'hFFFF)) begin
                force_q <= force_q + 16'd1;
            end
        end
    end

    assign bus.conflict_cnt_o = conflict_q;
    assign bus.force_cnt_o    = force_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (MAX_WAIT=8). Define RF_ARB_PERF_EN to
// also check the performance counters.
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    rf_write_arbiter_if #(.WIDTH(32), .RD(5)) bus ();

    rf_write_arbiter #(
        .WIDTH    (32),
        .RD       (5),
        .MAX_WAIT (8)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.wb_valid_i = wv;
        bus.wb_addr_i  = wa;
        bus.wb_data_i  = wd;
        bus.mc_valid_i = mv;
        bus.mc_addr_i  = ma;
        bus.mc_data_i  = md;
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h4);
        chk("ready_in_reset", 32'(bus.mc_ready_o), 32'd0);
        tick();
        tick();
        chk("rst_we", 32'(bus.rf_we_o), 32'd0);
        chk("rst_waddr", 32'(bus.rf_waddr_o), 32'd0);
        chk("rst_wdata", bus.rf_wdata_o, 32'd0);
        chk("rst_stall", 32'(bus.stall_pipe_o), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        tick();

        // WB x5 write
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        chk("wb_ready", 32'(bus.mc_ready_o), 32'd0);
        chk("wb_pre_we", 32'(bus.rf_we_o), 32'd0);
        tick();
        chk("wb_we", 32'(bus.rf_we_o), 32'd1);
        chk("wb_waddr", 32'(bus.rf_waddr_o), 32'd5);
        chk("wb_wdata", bus.rf_wdata_o, 32'hDEADBEEF);

        // MC x7 with WB idle
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
        chk("mc_ready", 32'(bus.mc_ready_o), 32'd1);
        tick();
        chk("mc_we", 32'(bus.rf_we_o), 32'd1);
        chk("mc_waddr", 32'(bus.rf_waddr_o), 32'd7);
        chk("mc_wdata", bus.rf_wdata_o, 32'h1234);
        chk("mc_state", 32'(dut.state_q), 32'(ARB_IDLE));

        // WB to x0 does not block MC x3
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd3, 32'hA);
        chk("wbx0_ready", 32'(bus.mc_ready_o), 32'd1);
        tick();
        chk("wbx0_we", 32'(bus.rf_we_o), 32'd1);
        chk("wbx0_waddr", 32'(bus.rf_waddr_o), 32'd3);
        chk("wbx0_wdata", bus.rf_wdata_o, 32'hA);

        // Idle cycle: we drops, address/data hold
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("idle_we", 32'(bus.rf_we_o), 32'd0);
        chk("idle_waddr", 32'(bus.rf_waddr_o), 32'd3);
        chk("idle_wdata", bus.rf_wdata_o, 32'hA);

        // MC to x0: accepted, no write
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF);
        chk("mcx0_ready", 32'(bus.mc_ready_o), 32'd1);
        tick();
        chk("mcx0_we", 32'(bus.rf_we_o), 32'd0);
        chk("mcx0_state", 32'(dut.state_q), 32'(ARB_IDLE));

        // Starvation: WB x1 every cycle while MC x9 waits
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 5'd1, 32'(i), 1'b1, 5'd9, 32'h99);
            chk("starve_ready", 32'(bus.mc_ready_o), 32'd0);
            tick();
            chk("starve_wb_data", bus.rf_wdata_o, 32'(i));
            chk("starve_stall", 32'(bus.stall_pipe_o), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("starve_state", 32'(dut.state_q), 32'(ARB_FORCE));
        // In-flight WB after the stall is seen still wins
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99);
        chk("force_ready", 32'(bus.mc_ready_o), 32'd0);
        tick();
        chk("force_wb_addr", 32'(bus.rf_waddr_o), 32'd2);
        chk("force_stall", 32'(bus.stall_pipe_o), 32'd1);
        chk("force_cnt_sat", 32'(dut.u_wait_cnt.count_q), 32'd8);
        // Pipeline drops WB, MC transfers
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
        chk("xfer_ready", 32'(bus.mc_ready_o), 32'd1);
        tick();
        chk("xfer_we", 32'(bus.rf_we_o), 32'd1);
        chk("xfer_waddr", 32'(bus.rf_waddr_o), 32'd9);
        chk("xfer_wdata", bus.rf_wdata_o, 32'h99);
        chk("xfer_stall", 32'(bus.stall_pipe_o), 32'd0);
        chk("xfer_state", 32'(dut.state_q), 32'(ARB_IDLE));
`ifdef RF_ARB_PERF_EN
        chk("perf_conflict", 32'(bus.conflict_cnt_o), 32'd9);
        chk("perf_force", 32'(bus.force_cnt_o), 32'd1);
`endif

        // Reach FORCE again, then reset in FORCE
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd10, 32'hAA);
            tick();
        end
        chk("force2_stall", 32'(bus.stall_pipe_o), 32'd1);
`ifdef RF_ARB_PERF_EN
        chk("perf_force2", 32'(bus.force_cnt_o), 32'd2);
`endif
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hAA);
        rst_n = 1'b0;
        #1;
        chk("rst2_ready", 32'(bus.mc_ready_o), 32'd0);
        tick();
        chk("rst2_stall", 32'(bus.stall_pipe_o), 32'd0);
        chk("rst2_we", 32'(bus.rf_we_o), 32'd0);
        chk("rst2_waddr", 32'(bus.rf_waddr_o), 32'd0);
        chk("rst2_state", 32'(dut.state_q), 32'(ARB_IDLE));
`ifdef RF_ARB_PERF_EN
        chk("rst2_force_cnt", 32'(bus.force_cnt_o), 32'd0);
        chk("rst2_conflict_cnt", 32'(bus.conflict_cnt_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
